// File: rtl/gen_regfile_sb_if.sv
// Request/response bundle for gen_regfile_sb.
// Issue and writeback drive it as master; the register file is the slave.
interface gen_regfile_sb_if #(
  parameter int WIDTH = 32,
  parameter int AW    = 5,
  parameter int NRD   = 2,
  parameter int SIZE  = 32
);
  logic                   wr_en;
  logic [AW-1:0]          wr_addr;
  logic [WIDTH-1:0]       wr_data;
  logic                   rsv_en;
  logic [AW-1:0]          rsv_addr;
  logic                   rsv_ok;
  logic [NRD-1:0]         rd_en;
  logic [NRD*AW-1:0]      rd_addr;
  logic [NRD*WIDTH-1:0]   rd_data;
  logic [NRD-1:0]         rd_ready;
  logic [SIZE-1:0]        busy;

  modport master (
    output wr_en, wr_addr, wr_data,
    output rsv_en, rsv_addr,
    output rd_en, rd_addr,
    input  rsv_ok, rd_data, rd_ready, busy
  );

  modport slave (
    input  wr_en, wr_addr, wr_data,
    input  rsv_en, rsv_addr,
    input  rd_en, rd_addr,
    output rsv_ok, rd_data, rd_ready, busy
  );
endinterface

// File: rtl/gen_regfile_sb.sv
// Register file with one write port, NRD registered read ports,
// write-to-read bypass and a per-register pending scoreboard.
module gen_regfile_sb #(
  parameter int WIDTH   = 32,
  parameter int SIZE    = 32,
  parameter int AW      = 5,
  parameter int NRD     = 2,
  parameter bit ZERO_R0 = 1'b1
) (
  input logic            clk,
  input logic            reset,
  gen_regfile_sb_if.slave rf
);

  localparam logic [AW:0] SZ = (AW+1)'(SIZE);

  function automatic logic in_range(
    input logic [AW-1:0] a
  );
    return {1'b0, a} < SZ;
  endfunction

  function automatic logic is_r0(
    input logic [AW-1:0] a
  );
    return ZERO_R0 && (a == '0);
  endfunction

  logic [WIDTH-1:0] regs [SIZE];
  logic [SIZE-1:0]  pend;
  logic [SIZE-1:0]  pend_nxt;
  logic [SIZE-1:0]  wr_dec;
  logic [SIZE-1:0]  rsv_dec;
  logic             wr_ok;
  logic             rsv_pend;
  logic             rsv_ok;
  logic             rsv_set;

  logic [WIDTH-1:0]     rd_q   [NRD];
  logic [NRD-1:0]       rdy_q;
  logic [WIDTH-1:0]     rd_d   [NRD];
  logic [NRD-1:0]       rdy_d;
  logic [NRD*WIDTH-1:0] rd_flat;

  always_comb begin
    wr_ok = rf.wr_en
          & in_range(rf.wr_addr)
          & ~is_r0(rf.wr_addr);
    rsv_pend = 1'b0;
    for (int i = 0; i < SIZE; i++) begin
      if (rf.rsv_addr == AW'(i)) rsv_pend = pend[i];
    end
    rsv_ok = rf.rsv_en
           & in_range(rf.rsv_addr)
           & (~rsv_pend
              | (rf.wr_en
                 & (rf.wr_addr == rf.rsv_addr)));
    // r0 accepts the request but never records it
    rsv_set = rsv_ok & ~is_r0(rf.rsv_addr);
    for (int i = 0; i < SIZE; i++) begin
      wr_dec[i]  = wr_ok
                 && (rf.wr_addr == AW'(i));
      rsv_dec[i] = rsv_set
                 && (rf.rsv_addr == AW'(i));
    end
    // reservation wins over a same-cycle write
    pend_nxt = (pend & ~wr_dec) | rsv_dec;
  end

  assign rf.rsv_ok = rsv_ok;
  assign rf.busy   = pend;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SIZE; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < SIZE; i++) begin
        if (wr_dec[i]) regs[i] <= rf.wr_data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pend <= '0;
    else        pend <= pend_nxt;
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]    a;
    logic [WIDTH-1:0] val;
    logic             pa;
    logic             hit;

    assign a   = rf.rd_addr[k*AW +: AW];
    assign hit = rf.wr_en && (rf.wr_addr == a);

    always_comb begin
      val = '0;
      pa  = 1'b0;
      for (int i = 0; i < SIZE; i++) begin
        if (a == AW'(i)) begin
          val = regs[i];
          pa  = pend[i];
        end
      end
      if (!in_range(a) || is_r0(a)) begin
        rd_d[k]  = '0;
        rdy_d[k] = 1'b1;
      end else begin
        rd_d[k]  = (hit && wr_ok)
                 ? rf.wr_data : val;
        rdy_d[k] = ~(pa & ~hit);
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        rd_q[k]  <= '0;
        rdy_q[k] <= 1'b0;
      end else if (rf.rd_en[k]) begin
        rd_q[k]  <= rd_d[k];
        rdy_q[k] <= rdy_d[k];
      end
    end
  end

  always_comb begin
    rd_flat = '0;
    for (int k = 0; k < NRD; k++) begin
      rd_flat[k*WIDTH +: WIDTH] = rd_q[k];
    end
  end

  assign rf.rd_data  = rd_flat;
  assign rf.rd_ready = rdy_q;

endmodule

// File: tb/tb_gen_regfile_sb.sv
// Scoreboard bench for gen_regfile_sb (SIZE=24, ZERO_R0=1, NRD=2):
// directed scenarios plus random traffic against an array model.
module tb_gen_regfile_sb;

  localparam int SZ = 24;

  logic clk;
  logic reset;

  gen_regfile_sb_if #(
    .WIDTH(32), .AW(5), .NRD(2), .SIZE(SZ)
  ) bus ();

  gen_regfile_sb #(
    .WIDTH(32), .SIZE(SZ), .AW(5),
    .NRD(2), .ZERO_R0(1'b1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rf(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rsv_ok;
    logic [63:0] d;
    logic [1:0]  r;
    logic [23:0] busy;
  } exp_t;

  exp_t exp_q[$];

  logic [31:0] mreg [SZ];
  bit          mpend [SZ];
  logic [31:0] md [2];
  bit          mr [2];

  int nvec;
  int nerr;

  task automatic chk(
    input string nm,
    input logic [63:0] act,
    input logic [63:0] req
  );
    nvec++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %h expected %h",
               nm, act, req);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < SZ; i++) begin
      mreg[i]  = '0;
      mpend[i] = 1'b0;
    end
    for (int k = 0; k < 2; k++) begin
      md[k] = '0;
      mr[k] = 1'b0;
    end
  endtask

  task automatic idle_inputs();
    bus.wr_en    = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.rsv_en   = 1'b0;
    bus.rsv_addr = '0;
    bus.rd_en    = '0;
    bus.rd_addr  = '0;
  endtask

  // one clock of stimulus; expectations go to the scoreboard
  task automatic cyc(
    input bit          we,
    input int          wa,
    input logic [31:0] wd,
    input bit          re,
    input int          ra,
    input bit [1:0]    rde,
    input int          a0,
    input int          a1
  );
    exp_t e;
    bit   wv;
    bit   ok;
    int   a;
    @(negedge clk);
    bus.wr_en    = we;
    bus.wr_addr  = 5'(wa);
    bus.wr_data  = wd;
    bus.rsv_en   = re;
    bus.rsv_addr = 5'(ra);
    bus.rd_en    = rde;
    bus.rd_addr  = {5'(a1), 5'(a0)};
    wv = we && wa < SZ && wa != 0;
    ok = re && ra < SZ
       && (!mpend[ra] || (we && wa == ra));
    for (int k = 0; k < 2; k++) begin
      a = (k == 0) ? a0 : a1;
      if (rde[k]) begin
        if (a >= SZ || a == 0) begin
          md[k] = '0;
          mr[k] = 1'b1;
        end else begin
          md[k] = (wv && wa == a) ? wd : mreg[a];
          mr[k] = !(mpend[a] && !(we && wa == a));
        end
      end
    end
    if (wv) begin
      mreg[wa]  = wd;
      mpend[wa] = 1'b0;
    end
    if (ok && ra != 0) mpend[ra] = 1'b1;
    e.rsv_ok = ok;
    e.d      = {md[1], md[0]};
    e.r      = {mr[1], mr[0]};
    for (int i = 0; i < SZ; i++) e.busy[i] = mpend[i];
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    reset = 1'b0;
    model_clear();
    #1;
    chk("reset busy", 64'(bus.busy), 64'd0);
    chk("reset rd_data", 64'(bus.rd_data), 64'd0);
    chk("reset rd_ready", 64'(bus.rd_ready), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  function automatic int raddr();
    if ($urandom_range(0, 3) == 0)
      return int'($urandom_range(0, 31));
    return int'($urandom_range(0, 11));
  endfunction

  task automatic rand_cycles(input int n);
    int wa;
    int ra;
    for (int i = 0; i < n; i++) begin
      wa = raddr();
      ra = ($urandom_range(0, 3) == 0) ? wa : raddr();
      cyc(bit'($urandom_range(0, 1)), wa, $urandom,
          $urandom_range(0, 3) != 0, ra,
          2'($urandom), raddr(), raddr());
    end
  endtask

  // monitor: rsv_ok before the edge, registered outputs after it
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() != 0) begin
        e = exp_q[0];
        chk("rsv_ok", 64'(bus.rsv_ok), 64'(e.rsv_ok));
        @(posedge clk);
        #1;
        chk("rd_data", 64'(bus.rd_data), e.d);
        chk("rd_ready", 64'(bus.rd_ready), 64'(e.r));
        chk("busy", 64'(bus.busy), 64'(e.busy));
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    nvec  = 0;
    nerr  = 0;
    reset = 1'b0;
    idle_inputs();
    model_clear();
    @(negedge clk);
    #1;
    chk("init busy", 64'(bus.busy), 64'd0);
    chk("init rd_ready", 64'(bus.rd_ready), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    cyc(0, 0, 0, 0, 0, 2'b01, 5, 0);
    cyc(1, 3, 32'hDEADBEEF, 0, 0, 2'b11, 3, 3);
    cyc(0, 0, 0, 1, 7, 2'b00, 0, 0);
    cyc(0, 0, 0, 0, 0, 2'b01, 7, 0);
    cyc(0, 0, 0, 1, 7, 2'b00, 0, 0);
    cyc(1, 7, 32'h55, 0, 0, 2'b10, 0, 7);
    cyc(0, 0, 0, 0, 0, 2'b11, 7, 3);
    cyc(1, 0, 32'hFFFFFFFF, 0, 0, 2'b00, 0, 0);
    cyc(0, 0, 0, 1, 0, 2'b00, 0, 0);
    cyc(0, 0, 0, 0, 0, 2'b11, 0, 0);
    cyc(0, 0, 0, 1, 9, 2'b00, 0, 0);
    cyc(1, 9, 32'hA5A5_0009, 1, 9, 2'b01, 9, 0);
    cyc(0, 0, 0, 0, 0, 2'b10, 0, 9);
    cyc(1, 30, 32'h1234, 0, 0, 2'b00, 0, 0);
    cyc(0, 0, 0, 0, 0, 2'b11, 30, 30);
    cyc(0, 0, 0, 1, 30, 2'b00, 0, 0);
    cyc(0, 0, 0, 0, 0, 2'b11, 9, 3);
    cyc(1, 3, 32'h1111, 1, 5, 2'b00, 3, 3);
    cyc(0, 5, 0, 0, 0, 2'b00, 5, 5);
    cyc(0, 0, 0, 0, 0, 2'b00, 0, 0);

    rand_cycles(400);
    do_reset();
    cyc(0, 0, 0, 0, 0, 2'b11, 5, 9);
    rand_cycles(400);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++)
      @(negedge clk);
    if (exp_q.size() != 0) begin
      nerr++;
      $display("FAIL drain: %0d entries left, expected 0",
               exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
